vga_sync_gen: RTL and testbench

- Generates VGA raster timing for the display path: pixel-rate clock enable, row/column counters, hsync/vsync and active-video.
- Drives `row`/`col` to the pixel generators (colour stripes, colour wheel).
- Takes their registered 4-bit RGB back, re-aligns it with the delayed sync signals, and drives the physical VGA pins.
- Blanks RGB outside the active area.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_pixel_tick.sv | 46 ++++
 rtl/vga_sync_gen.sv | 184 ++++++++++++++++++
 tb/tb_vga_sync_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 constants, line/frame totals and
// the per-stage record carried through the sync pipeline.
// Optional feature macro used by vga_sync_gen: VGA_BORDER_EN.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_CNT_W    = 11;

    // Total length of one axis: visible region plus the three blanking parts.
    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = calc_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = calc_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // One pipeline stage: active-low syncs, active-area flag, border flag.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic border;
    } sync_stage_t;

    localparam sync_stage_t SYNC_STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, border: 1'b0};

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate clock enable: divides clk by CLK_DIV (2..16). pix_tick is a
// registered one-clk pulse on the last count; pre_tick is high in the cycle
// before pix_tick so downstream logic can register outputs that align with it.
module vga_pixel_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick,
    output logic pre_tick
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_next_s;
    logic             pre_tick_s;
    logic             pix_tick_r;

    // Next divider count and look-ahead of the tick.
    always_comb begin
        if (div_cnt_r == DIV_LAST) begin
            div_cnt_next_s = {DIV_W{1'b0}};
        end else begin
            div_cnt_next_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
        pre_tick_s = (div_cnt_r == DIV_PRE);
    end

    // Divider counter; the tick register equals (div_cnt == CLK_DIV-1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            pix_tick_r <= 1'b0;
        end else begin
            div_cnt_r  <= div_cnt_next_s;
            pix_tick_r <= pre_tick_s;
        end
    end

    assign pix_tick = pix_tick_r;
    assign pre_tick = pre_tick_s;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel enable, row/col counters, delayed
// hsync/vsync/video_on and blanked, re-aligned RGB for the VGA pins.
// Optional macro VGA_BORDER_EN forces a white 1-pixel frame around the
// active area.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int CLK_DIV    = VGA_CLK_DIV,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [10:0] row,
    output logic [10:0] col,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
`endif

    logic        tick_s;
    logic        pre_tick_s;
    logic [10:0] row_r;
    logic [10:0] col_r;
    logic        frame_start_r;
    sync_stage_t raw_s;
    sync_stage_t stage_in_s [SYNC_DELAY];
    sync_stage_t pipe_r     [SYNC_DELAY];
    sync_stage_t final_in_s;
    logic [11:0] rgb_next_s;
    logic [11:0] rgb_r;
    logic        unused_border_s;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (tick_s),
        .pre_tick (pre_tick_s)
    );

    // Raster counters: col wraps at end of line and carries into row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= 11'd0;
            row_r <= 11'd0;
        end else if (tick_s) begin
            if (col_r == H_LAST) begin
                col_r <= 11'd0;
                if (row_r == V_LAST) begin
                    row_r <= 11'd0;
                end else begin
                    row_r <= row_r + 11'd1;
                end
            end else begin
                col_r <= col_r + 11'd1;
            end
        end
    end

    // Frame-start pulse, registered one cycle ahead so it coincides with the
    // pix_tick that ends the last pixel (counters are stable across that edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pre_tick_s && (col_r == H_LAST) && (row_r == V_LAST);
        end
    end

    // Decode raw sync/active/border flags from the current counters.
    always_comb begin
        raw_s     = SYNC_STAGE_IDLE;
        raw_s.hs  = !((col_r >= HS_START) && (col_r < HS_END));
        raw_s.vs  = !((row_r >= VS_START) && (row_r < VS_END));
        raw_s.act = (col_r < H_ACT) && (row_r < V_ACT);
`ifdef VGA_BORDER_EN
        raw_s.border = raw_s.act && ((col_r == 11'd0) || (col_r == H_ACT_LAST) ||
                                     (row_r == 11'd0) || (row_r == V_ACT_LAST));
`else
        raw_s.border = 1'b0;
`endif
    end

    // Input of each pipeline stage: raw decode feeds stage 0, others chain.
    always_comb begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
            stage_in_s[i] = SYNC_STAGE_IDLE;
        end
        stage_in_s[0] = raw_s;
        for (int i = 1; i < SYNC_DELAY; i++) begin
            stage_in_s[i] = pipe_r[i-1];
        end
        final_in_s = stage_in_s[SYNC_DELAY-1];
    end

    // Sync pipeline shifting once per pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                pipe_r[i] <= SYNC_STAGE_IDLE;
            end
        end else if (tick_s) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                pipe_r[i] <= stage_in_s[i];
            end
        end
    end

    // Colour for the pixel entering the final stage: blank outside active area.
    always_comb begin
        rgb_next_s = 12'h000;
        if (final_in_s.act) begin
`ifdef VGA_BORDER_EN
            if (final_in_s.border) begin
                rgb_next_s = 12'hFFF;
            end else begin
                rgb_next_s = {red_in, green_in, blue_in};
            end
`else
            rgb_next_s = {red_in, green_in, blue_in};
`endif
        end else begin
            rgb_next_s = 12'h000;
        end
    end

    // Colour registers load on the same edge as the final sync stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r <= 12'h000;
        end else if (tick_s) begin
            rgb_r <= rgb_next_s;
        end
    end

    // The final-stage border flag has no consumer: colour decides from the
    // stage input so colour and sync move together.
    assign unused_border_s = pipe_r[SYNC_DELAY-1].border;

    assign row         = row_r;
    assign col         = col_r;
    assign pix_tick    = tick_s;
    assign frame_start = frame_start_r;
    assign hsync       = pipe_r[SYNC_DELAY-1].hs;
    assign vsync       = pipe_r[SYNC_DELAY-1].vs;
    assign video_on    = pipe_r[SYNC_DELAY-1].act;
    assign red         = rgb_r[11:8];
    assign green       = rgb_r[7:4];
    assign blue        = rgb_r[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster (24x14 pixels, CLK_DIV 4) so
// several whole frames fit in a short run. A reference model computes the
// expected raster state after n pixel ticks with plain arithmetic; the model
// pushes one record per tick into a scoreboard and a monitor pops it whenever
// the DUT raises pix_tick. Colour comes from a random per-pixel table,
// presented one clk after the counters change.
module tb_vga_sync_gen;

    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int DIV = 4;
    localparam int DLY = 1;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic [10:0] row;
        logic [10:0] col;
        logic        hs;
        logic        vs;
        logic        von;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  red_in = 4'h0;
    logic [3:0]  green_in = 4'h0;
    logic [3:0]  blue_in = 4'h0;
    logic [10:0] row;
    logic [10:0] col;
    logic        pix_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    int          checks = 0;
    int          passed = 0;
    int          mclk = 0;
    int          gen_idx;
    logic [11:0] lut [FT];
    exp_t        sb [$];

    vga_sync_gen #(
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HS),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .CLK_DIV    (DIV),
        .SYNC_DELAY (DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .row         (row),
        .col         (col),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_border(input int r, input int c);
`ifdef VGA_BORDER_EN
        return (c == 0) || (c == HA - 1) || (r == 0) || (r == VA - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs after n pixel ticks since reset release.
    function automatic exp_t model_state(input int n);
        exp_t e;
        int p, q, pc, pr;
        p     = n % FT;
        e.row = 11'(p / HT);
        e.col = 11'(p % HT);
        if (n < DLY) begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.von = 1'b0;
            e.rgb = 12'h000;
        end else begin
            q     = (n - DLY) % FT;
            pc    = q % HT;
            pr    = q / HT;
            e.hs  = !((pc >= HA + HF) && (pc < HA + HF + HS));
            e.vs  = !((pr >= VA + VF) && (pr < VA + VF + VS));
            e.von = (pc < HA) && (pr < VA);
            if (!e.von) begin
                e.rgb = 12'h000;
            end else if (is_border(pr, pc)) begin
                e.rgb = 12'hFFF;
            end else begin
                e.rgb = lut[(n - 1) % FT];
            end
        end
        return e;
    endfunction

    // Reference model: counts clks since release, queues expected state per tick.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mclk <= 0;
            sb.delete();
            sb.push_back(model_state(0));
        end else begin
            mclk <= mclk + 1;
            if (((mclk + 1) % DIV) == 0) begin
                sb.push_back(model_state((mclk + 1) / DIV));
            end
        end
    end

    // Pixel generator: colour for the current counters, one clk later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            gen_idx = int'(row) * HT + int'(col);
            if (gen_idx < FT) begin
                {red_in, green_in, blue_in} = lut[gen_idx];
            end else begin
                {red_in, green_in, blue_in} = 12'h000;
            end
        end
    end

    // Monitor: tick timing every cycle, full output state on every pix_tick.
    initial begin
        exp_t e;
        logic exp_tick;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_tick = ((mclk % DIV) == DIV - 1);
                check("pix_tick", {31'd0, pix_tick}, {31'd0, exp_tick});
                check("frame_start", {31'd0, frame_start},
                      {31'd0, exp_tick && (((mclk / DIV) % FT) == FT - 1)});
                if (pix_tick) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL scoreboard: got pix_tick with no expected entry at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("col", {21'd0, col}, {21'd0, e.col});
                        check("row", {21'd0, row}, {21'd0, e.row});
                        check("hsync", {31'd0, hsync}, {31'd0, e.hs});
                        check("vsync", {31'd0, vsync}, {31'd0, e.vs});
                        check("video_on", {31'd0, video_on}, {31'd0, e.von});
                        check("rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_row"}, {21'd0, row}, 32'd0);
        check({tag, "_col"}, {21'd0, col}, 32'd0);
        check({tag, "_pix_tick"}, {31'd0, pix_tick}, 32'd0);
        check({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
        check({tag, "_hsync"}, {31'd0, hsync}, 32'd1);
        check({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        check({tag, "_video_on"}, {31'd0, video_on}, 32'd0);
        check({tag, "_rgb"}, {20'd0, red, green, blue}, 32'd0);
    endtask

    // Stimulus: power-on reset, free run, mid-line reset, random resets.
    initial begin
        int guard;
        for (int i = 0; i < FT; i++) begin
            lut[i] = 12'($urandom);
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 check_reset_vals("por");
        @(negedge clk);
        #1 rst = 1'b0;

        repeat (2 * FT * DIV + 20) @(posedge clk);

        guard = 0;
        while (!((row == 11'd5) && (col == 11'd10)) && (guard < 2 * FT * DIV)) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 2 * FT * DIV) begin
            checks++;
            $display("FAIL midline_wait: got no (row 5, col 10) within %0d clks", guard);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_vals("midline");
        repeat (3) @(posedge clk);
        #2 check_reset_vals("midline_hold");
        @(negedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(50, 1500)) @(posedge clk);
            #1 rst = 1'b1;
            #1 check_reset_vals("random");
            repeat ($urandom_range(1, 4)) @(posedge clk);
            @(negedge clk);
            #1 rst = 1'b0;
        end

        repeat (FT * DIV + 50) @(posedge clk);
        @(negedge clk);
        #1 check("sb_depth", {31'd0, (sb.size() <= 1)}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
